// File: rtl/ocs_sync_rx.sv
// rtl/ocs_sync_rx.sv - slot-sync frame receiver: parses sync frames from RX AXI-Stream
// and runs the local slot timer with loss-of-lock detection.
module ocs_sync_rx #(
  parameter logic [15:0] P_ETH_TYPE   = 16'h88B5,
  parameter logic [7:0]  P_SYNC_TYPE  = 8'h01,
  parameter int          P_SLOT_NUM   = 8,
  parameter int          P_LOSS_SLOTS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_axis_tvalid,
  input  logic [63:0] i_rx_axis_tdata,
  input  logic        i_rx_axis_tlast,
  input  logic [7:0]  i_rx_axis_tkeep,
  input  logic        i_rx_axis_tuser,
  output logic        o_sync_valid,
  output logic [7:0]  o_slot_id,
  output logic [31:0] o_slot_len,
  output logic [15:0] o_guard_len,
  output logic        o_slot_active,
  output logic        o_guard,
  output logic        o_locked,
  output logic [15:0] o_err_cnt
);
  localparam logic [7:0] LP_SLOT_NUM = 8'(P_SLOT_NUM);
  localparam logic [7:0] LP_LOSS     = 8'(P_LOSS_SLOTS);

  typedef enum logic [1:0] {S_IDLE, S_BEAT1, S_BEAT2, S_TAIL} state_t;

  state_t      state_q, state_d;
  logic        armed_q, armed_d;
  logic [15:0] eth_q, eth_d;
  logic [7:0]  typ_q, typ_d;
  logic [7:0]  fid_q, fid_d;
  logic [31:0] flen_q, flen_d;
  logic [15:0] fguard_q, fguard_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  loss_q, loss_d;
  logic        sync_valid_q, sync_valid_d;
  logic [7:0]  slot_id_q, slot_id_d;
  logic [31:0] slot_len_q, slot_len_d;
  logic [15:0] guard_len_q, guard_len_d;
  logic        active_q, active_d;
  logic        guard_q, guard_d;
  logic        locked_q, locked_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        frame_end, reached, fields_ok, commit, reject;
  logic [31:0] cur_len;
  logic [15:0] cur_guard;
  logic        unused_ok;

  assign unused_ok = ^{i_rx_axis_tkeep, i_rx_axis_tdata[63:48]};

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    eth_d       = eth_q;
    typ_d       = typ_q;
    fid_d       = fid_q;
    flen_d      = flen_q;
    fguard_d    = fguard_q;
    frame_end   = 1'b0;
    reached     = 1'b0;
    cur_len     = flen_q;
    cur_guard   = fguard_q;
    case (state_q)
      S_IDLE: begin
        if (i_rx_axis_tvalid) begin
          if (i_rx_axis_tlast) frame_end = 1'b1;
          else                 state_d   = S_BEAT1;
        end
      end
      S_BEAT1: begin
        if (i_rx_axis_tvalid) begin
          eth_d = {i_rx_axis_tdata[39:32], i_rx_axis_tdata[47:40]};
          typ_d = i_rx_axis_tdata[55:48];
          fid_d = i_rx_axis_tdata[63:56];
          if (i_rx_axis_tlast) begin
            frame_end = 1'b1;
            state_d   = S_IDLE;
          end else begin
            state_d = S_BEAT2;
          end
        end
      end
      S_BEAT2: begin
        if (i_rx_axis_tvalid) begin
          cur_len   = {i_rx_axis_tdata[7:0], i_rx_axis_tdata[15:8],
                       i_rx_axis_tdata[23:16], i_rx_axis_tdata[31:24]};
          cur_guard = {i_rx_axis_tdata[39:32], i_rx_axis_tdata[47:40]};
          flen_d    = cur_len;
          fguard_d  = cur_guard;
          reached   = 1'b1;
          if (i_rx_axis_tlast) begin
            frame_end = 1'b1;
            state_d   = S_IDLE;
          end else begin
            armed_d = 1'b1;
            state_d = S_TAIL;
          end
        end
      end
      default: begin
        // An unarmed TAIL is the post-reset resync: its tlast is dropped silently.
        if (i_rx_axis_tvalid && i_rx_axis_tlast) begin
          frame_end = armed_q;
          reached   = armed_q;
          armed_d   = 1'b0;
          state_d   = S_IDLE;
        end
      end
    endcase

    fields_ok = !i_rx_axis_tuser && (eth_d == P_ETH_TYPE) && (typ_d == P_SYNC_TYPE) &&
                (fid_d < LP_SLOT_NUM) && (cur_guard != 16'd0) &&
                (cur_len > {16'd0, cur_guard});
    commit = frame_end && reached && fields_ok;
    reject = frame_end && !commit;

    sync_valid_d = commit;
    slot_id_d    = slot_id_q;
    slot_len_d   = slot_len_q;
    guard_len_d  = guard_len_q;
    timer_d      = timer_q;
    loss_d       = loss_q;
    locked_d     = locked_q;
    if (commit) begin
      slot_id_d   = fid_d;
      slot_len_d  = cur_len;
      guard_len_d = cur_guard;
      timer_d     = 32'd0;
      loss_d      = 8'd0;
      locked_d    = 1'b1;
    end else if (locked_q) begin
      if (timer_q == slot_len_q - 32'd1) begin
        timer_d   = 32'd0;
        slot_id_d = (slot_id_q == LP_SLOT_NUM - 8'd1) ? 8'd0 : slot_id_q + 8'd1;
        loss_d    = loss_q + 8'd1;
        if (loss_q + 8'd1 == LP_LOSS) locked_d = 1'b0;
      end else begin
        timer_d = timer_q + 32'd1;
      end
    end
    active_d = locked_d && (timer_d < slot_len_d - {16'd0, guard_len_d});
    guard_d  = locked_d && !active_d;

    err_cnt_d = err_cnt_q;
    if (reject && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_TAIL;
      armed_q      <= 1'b0;
      eth_q        <= 16'd0;
      typ_q        <= 8'd0;
      fid_q        <= 8'd0;
      flen_q       <= 32'd0;
      fguard_q     <= 16'd0;
      timer_q      <= 32'd0;
      loss_q       <= 8'd0;
      sync_valid_q <= 1'b0;
      slot_id_q    <= 8'd0;
      slot_len_q   <= 32'd0;
      guard_len_q  <= 16'd0;
      active_q     <= 1'b0;
      guard_q      <= 1'b0;
      locked_q     <= 1'b0;
      err_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      eth_q        <= eth_d;
      typ_q        <= typ_d;
      fid_q        <= fid_d;
      flen_q       <= flen_d;
      fguard_q     <= fguard_d;
      timer_q      <= timer_d;
      loss_q       <= loss_d;
      sync_valid_q <= sync_valid_d;
      slot_id_q    <= slot_id_d;
      slot_len_q   <= slot_len_d;
      guard_len_q  <= guard_len_d;
      active_q     <= active_d;
      guard_q      <= guard_d;
      locked_q     <= locked_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign o_sync_valid  = sync_valid_q;
  assign o_slot_id     = slot_id_q;
  assign o_slot_len    = slot_len_q;
  assign o_guard_len   = guard_len_q;
  assign o_slot_active = active_q;
  assign o_guard       = guard_q;
  assign o_locked      = locked_q;
  assign o_err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_ocs_sync_rx.sv
// tb/tb_ocs_sync_rx.sv - scoreboard bench for ocs_sync_rx with an arithmetic slot-timing model.
module tb_ocs_sync_rx;
  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid, tlast, tuser;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        sync_valid, slot_active, guard, locked;
  logic [7:0]  slot_id;
  logic [31:0] slot_len;
  logic [15:0] guard_len, err_cnt;

  ocs_sync_rx dut (
    .i_clk(clk), .i_rst(rst),
    .i_rx_axis_tvalid(tvalid), .i_rx_axis_tdata(tdata), .i_rx_axis_tlast(tlast),
    .i_rx_axis_tkeep(tkeep), .i_rx_axis_tuser(tuser),
    .o_sync_valid(sync_valid), .o_slot_id(slot_id), .o_slot_len(slot_len),
    .o_guard_len(guard_len), .o_slot_active(slot_active), .o_guard(guard),
    .o_locked(locked), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int cyc; logic [7:0] sid; logic [31:0] len; logic [15:0] grd; } commit_t;
  typedef struct { int cyc; int val; } err_t;
  commit_t cq[$];
  err_t    eq[$];

  // Reference model: position inside the rotation derived from elapsed cycles since commit.
  bit          m_lock = 0;
  int          m_c0, m_err = 0;
  logic [7:0]  m_sid;
  int          m_len, m_grd;

  always @(negedge clk) begin
    if (rst) begin
      m_lock = 0;
      m_err  = 0;
      cq.delete();
      eq.delete();
    end else begin
      commit_t c;
      int e, slots, pos;
      bit exp_act;
      while (cq.size() > 0 && cq[0].cyc < cyc) begin
        chk("commit_missing", 0, 1);
        void'(cq.pop_front());
      end
      if (cq.size() > 0 && cq[0].cyc == cyc) begin
        c = cq.pop_front();
        chk("sync_valid", sync_valid, 1);
        chk("commit_slot_id", slot_id, c.sid);
        chk("commit_slot_len", slot_len, c.len);
        chk("commit_guard_len", guard_len, c.grd);
        m_lock = 1; m_c0 = cyc; m_sid = c.sid; m_len = c.len; m_grd = c.grd;
      end else begin
        chk("no_spurious_sync", sync_valid, 0);
      end
      while (eq.size() > 0 && eq[0].cyc <= cyc) m_err = eq.pop_front().val;
      chk("err_cnt", err_cnt, m_err);
      if (m_lock) begin
        e = cyc - m_c0;
        slots = e / m_len;
        pos = e % m_len;
        if (slots >= 4) m_lock = 0;
      end
      exp_act = m_lock && (pos < m_len - m_grd);
      chk("locked", locked, m_lock);
      chk("slot_active", slot_active, exp_act);
      chk("guard", guard, m_lock && !exp_act);
      if (m_lock) chk("slot_id", slot_id, (m_sid + slots) % 8);
    end
  end

  int exp_err = 0;
  int last_commit = 0;

  task automatic drive(input logic v, input logic [63:0] d, input logic l,
                       input logic [7:0] k, input logic u);
    @(posedge clk);
    #1;
    tvalid = v; tdata = d; tlast = l; tkeep = k; tuser = u;
  endtask

  task automatic idle();
    drive(1'b0, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic send_frame(input logic [15:0] eth, input logic [7:0] typ, input logic [7:0] sid,
                            input logic [31:0] len, input logic [15:0] grd, input logic bad_fcs,
                            input int nbeats, input bit gaps, input int stop_after);
    logic [7:0]  fb [0:47];
    logic [63:0] d;
    bit          accept, last;
    for (int i = 0; i < 48; i++) fb[i] = 8'($urandom);
    fb[12] = eth[15:8]; fb[13] = eth[7:0]; fb[14] = typ; fb[15] = sid;
    fb[16] = len[31:24]; fb[17] = len[23:16]; fb[18] = len[15:8]; fb[19] = len[7:0];
    fb[20] = grd[15:8]; fb[21] = grd[7:0];
    accept = nbeats >= 3 && !bad_fcs && eth == 16'h88B5 && typ == 8'h01 && sid < 8 &&
             grd != 0 && len > {16'd0, grd};
    for (int b = 0; b < nbeats; b++) begin
      if (b == stop_after) return;
      if (gaps && $urandom_range(0, 3) == 0) idle();
      for (int n = 0; n < 8; n++) d[8*n +: 8] = fb[b*8 + n];
      last = (b == nbeats - 1);
      drive(1'b1, d, last, last ? 8'($urandom_range(1, 255)) : 8'hFF,
            last ? bad_fcs : 1'($urandom_range(0, 1)));
    end
    if (accept) begin
      cq.push_back('{cyc + 1, sid, len, grd});
      last_commit = cyc + 1;
    end else begin
      if (exp_err < 65535) exp_err++;
      eq.push_back('{cyc + 1, exp_err});
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_sync_valid", sync_valid, 0);
    chk("rst_slot_id", slot_id, 0);
    chk("rst_slot_len", slot_len, 0);
    chk("rst_guard_len", guard_len, 0);
    chk("rst_slot_active", slot_active, 0);
    chk("rst_guard", guard, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_cnt", err_cnt, 0);
  endtask

  initial begin
    int k, target, r, nb;
    logic [15:0] eth, g;
    logic [7:0]  typ, sid;
    logic [31:0] len;
    logic        fcs;
    tvalid = 0; tdata = 0; tlast = 0; tkeep = 0; tuser = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 0;
    // Resync beat: closes the frame that reset may have interrupted.
    drive(1'b1, 64'd0, 1'b1, 8'hFF, 1'b0);
    repeat (3) idle();

    send_frame(16'h88B5, 8'h01, 8'd3, 32'd1000, 16'd100, 1'b0, 3, 0, -1);
    repeat (20) idle();
    send_frame(16'h88B5, 8'h01, 8'd3, 32'd1000, 16'd100, 1'b1, 3, 0, -1);
    idle();
    send_frame(16'h0800, 8'h01, 8'd3, 32'd1000, 16'd100, 1'b0, 3, 0, -1);
    send_frame(16'h88B5, 8'h01, 8'd8, 32'd1000, 16'd100, 1'b0, 3, 0, -1);
    repeat (1010) idle();
    send_frame(16'h88B5, 8'h01, 8'd2, 32'd500, 16'd10, 1'b0, 2, 0, -1);
    repeat (4) idle();

    send_frame(16'h88B5, 8'h01, 8'd7, 32'd50, 16'd10, 1'b0, 4, 1, -1);
    repeat (220) idle();

    send_frame(16'h88B5, 8'h01, 8'd1, 32'd40, 16'd8, 1'b0, 3, 0, -1);
    k = (cyc - last_commit) / 40 + 2;
    target = last_commit + k * 40;
    while (cyc < target - 4) idle();
    send_frame(16'h88B5, 8'h01, 8'd5, 32'd40, 16'd8, 1'b0, 3, 0, -1);
    repeat (60) idle();

    send_frame(16'h88B5, 8'h01, 8'd6, 32'd30, 16'd5, 1'b0, 4, 0, 2);
    @(posedge clk);
    #1;
    tvalid = 0;
    rst = 1;
    exp_err = 0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    drive(1'b1, {$urandom, $urandom}, 1'b0, 8'hFF, 1'b0);
    drive(1'b1, {$urandom, $urandom}, 1'b1, 8'h0F, 1'b0);
    send_frame(16'h88B5, 8'h01, 8'd4, 32'd30, 16'd5, 1'b0, 3, 0, -1);
    repeat (10) idle();

    for (int f = 0; f < 40; f++) begin
      eth = 16'h88B5; typ = 8'h01; sid = 8'($urandom_range(0, 7));
      g = 16'($urandom_range(1, 20)); len = 32'(g) + $urandom_range(1, 60);
      fcs = 0; nb = $urandom_range(3, 5);
      r = $urandom_range(0, 11);
      case (r)
        0: fcs = 1;
        1: eth = 16'h0800;
        2: typ = 8'($urandom_range(2, 255));
        3: sid = 8'($urandom_range(8, 255));
        4: g = 16'd0;
        5: len = $urandom_range(0, 32'(g));
        6: nb = $urandom_range(1, 2);
        default: ;
      endcase
      send_frame(eth, typ, sid, len, g, fcs, nb, 1, -1);
      repeat ($urandom_range(0, 30)) idle();
    end
    repeat (300) idle();
    chk("queues_drained", cq.size() + eq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
